// File: rtl/bm_rd_arb_pkg.sv
// Types and the grant-selection rule shared by the BM read arbiter.
package bm_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    // On a tie the requester that did not own the port last time wins.
    function automatic arb_state_e pick_owner(input logic en0, input logic en1, input logic last_owner);
        arb_state_e s;
        if (en0 && en1) begin
            s = last_owner ? ST_OWN0 : ST_OWN1;
        end else if (en0) begin
            s = ST_OWN0;
        end else if (en1) begin
            s = ST_OWN1;
        end else begin
            s = ST_IDLE;
        end
        return s;
    endfunction

endpackage

// File: rtl/bm_tag_fifo.sv
// Synchronous 1-bit tag FIFO recording which requester issued each outstanding BM read.
module bm_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic pop_tag,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;
    logic             bypass;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Push+pop on an empty FIFO passes the tag straight through; at full the pop frees the slot.
    always_comb begin
        bypass  = push && pop && empty;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop) && !bypass;
        pop_tag = bypass ? push_tag : mem[rd_ptr];
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/incl.vh
// Shared block-memory geometry used by every BM client.
`ifndef BM_DEPTH
`define BM_DEPTH 256
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif

// File: rtl/bm_rd_arb.sv
// Two-requester burst arbiter for the shared BM read port, with in-order return routing.
`include "incl.vh"
module bm_rd_arb
    import bm_rd_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rq0_rd_en,
    input  logic [$clog2(`BM_DEPTH)-1:0]      rq0_rd_addr,
    output logic                              rq0_rd_rdy,
    input  logic                              rq1_rd_en,
    input  logic [$clog2(`BM_DEPTH)-1:0]      rq1_rd_addr,
    output logic                              rq1_rd_rdy,
    output logic                              bm_rd_en,
    output logic [$clog2(`BM_DEPTH)-1:0]      bm_rd_addr,
    input  logic [`BM_DATA_WIDTH-1:0]         bm_dout,
    input  logic                              bm_dout_vld,
    output logic [`BM_DATA_WIDTH-1:0]         rq0_dout,
    output logic                              rq0_dout_vld,
    output logic [`BM_DATA_WIDTH-1:0]         rq1_dout,
    output logic                              rq1_dout_vld
);
    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e                  state, state_nxt;
    logic                        last_owner, last_owner_nxt;
    logic [CW-1:0]               beat_cnt, beat_cnt_nxt;
    logic                        own_id;
    logic                        own_en;
    logic                        accept;
    logic                        tag_full, tag_empty, tag_pop, pop_tag;
    logic [`BM_DATA_WIDTH-1:0]   dout_r;

    // rdy is gated by rst so nothing is accepted while the block is held in reset.
    assign rq0_rd_rdy = (state == ST_OWN0) && !tag_full && !rst;
    assign rq1_rd_rdy = (state == ST_OWN1) && !tag_full && !rst;
    assign own_id     = (state == ST_OWN1);
    assign own_en     = own_id ? rq1_rd_en : rq0_rd_en;
    assign accept     = (rq0_rd_rdy && rq0_rd_en) || (rq1_rd_rdy && rq1_rd_en);
    assign tag_pop    = bm_dout_vld && !tag_empty;

    // Next-state: bursts end on the last beat or when the owner lets go; a full-FIFO stall holds.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            ST_IDLE: begin
                state_nxt = pick_owner(rq0_rd_en, rq1_rd_en, last_owner);
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_en || (accept && (beat_cnt == CW'(BURST_LEN - 1)))) begin
                    last_owner_nxt = own_id;
                    beat_cnt_nxt   = '0;
                    state_nxt      = pick_owner(rq0_rd_en, rq1_rd_en, own_id);
                end else if (accept) begin
                    beat_cnt_nxt   = beat_cnt + CW'(1);
                end else begin
                    beat_cnt_nxt   = beat_cnt;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Registered BM read port; address holds between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            bm_rd_en   <= 1'b0;
            bm_rd_addr <= '0;
        end else begin
            bm_rd_en <= accept;
            if (accept) begin
                bm_rd_addr <= own_id ? rq1_rd_addr : rq0_rd_addr;
            end else begin
                bm_rd_addr <= bm_rd_addr;
            end
        end
    end

    bm_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_tag (own_id),
        .pop      (tag_pop),
        .pop_tag  (pop_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Return routing: data returning with no outstanding tag is silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq0_dout_vld <= 1'b0;
            rq1_dout_vld <= 1'b0;
            dout_r       <= '0;
        end else begin
            rq0_dout_vld <= tag_pop && !pop_tag;
            rq1_dout_vld <= tag_pop && pop_tag;
            if (tag_pop) begin
                dout_r <= bm_dout;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign rq0_dout = dout_r;
    assign rq1_dout = dout_r;

endmodule

// File: tb/tb_bm_rd_arb.sv
// Scoreboard bench for bm_rd_arb: directed scenarios plus randomized traffic against a rule-level model.
`ifndef BM_DEPTH
`define BM_DEPTH 256
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif
module tb_bm_rd_arb;
    localparam int AW = $clog2(`BM_DEPTH);
    localparam int DW = `BM_DATA_WIDTH;
    localparam int BL = 4;
    localparam int TD = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        int            cyc;
    } bm_exp_t;

    logic          clk, rst;
    logic          rq0_rd_en, rq1_rd_en, rq0_rd_rdy, rq1_rd_rdy;
    logic [AW-1:0] rq0_rd_addr, rq1_rd_addr, bm_rd_addr;
    logic          bm_rd_en, bm_dout_vld, rq0_dout_vld, rq1_dout_vld;
    logic [DW-1:0] bm_dout, rq0_dout, rq1_dout;

    bm_rd_arb #(.BURST_LEN(BL), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .rq0_rd_en(rq0_rd_en), .rq0_rd_addr(rq0_rd_addr), .rq0_rd_rdy(rq0_rd_rdy),
        .rq1_rd_en(rq1_rd_en), .rq1_rd_addr(rq1_rd_addr), .rq1_rd_rdy(rq1_rd_rdy),
        .bm_rd_en(bm_rd_en), .bm_rd_addr(bm_rd_addr),
        .bm_dout(bm_dout), .bm_dout_vld(bm_dout_vld),
        .rq0_dout(rq0_dout), .rq0_dout_vld(rq0_dout_vld),
        .rq1_dout(rq1_dout), .rq1_dout_vld(rq1_dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0, bad = 0, cyc = 0, lat = 2, ring_cnt = 0;
    bit            spur = 0, rst_req = 1, gate0 = 1, gate1 = 1;
    logic [AW-1:0] rq0_q[$], rq1_q[$];
    logic [DW-1:0] exp0[$], exp1[$];
    bm_exp_t       bmq[$];
    logic [DW-1:0] mem [0:`BM_DEPTH-1];
    bit            ring_vld [0:63];
    logic [DW-1:0] ring_data [0:63];
    // reference model: owner -1 means nobody holds the port
    int            m_owner = -1, m_last = 1, m_beats = 0, m_out = 0;

    task automatic chk(input bit ok, input string name, input longint unsigned act, input longint unsigned expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int pick(input bit e0, input bit e1, input int last);
        if (e0 && e1) return (last == 1) ? 0 : 1;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    function automatic bit busy();
        return rq0_q.size() > 0 || rq1_q.size() > 0 || m_out > 0 || bmq.size() > 0 ||
               ring_cnt > 0 || exp0.size() > 0 || exp1.size() > 0;
    endfunction

    // One clock cycle: drive environment, check rdy, then advance the model on the edge.
    task automatic cycle();
        int  slot;
        bit  e0, e1, acc, pop;
        logic [AW-1:0] a;
        #1;
        if (bm_rd_en === 1'b1) begin
            slot = (cyc + lat) % 64;
            ring_vld[slot]  = 1'b1;
            ring_data[slot] = mem[bm_rd_addr];
            ring_cnt++;
        end
        slot = cyc % 64;
        bm_dout_vld = ring_vld[slot] || spur;
        bm_dout     = ring_vld[slot] ? ring_data[slot] : DW'($urandom);
        if (ring_vld[slot]) ring_cnt--;
        ring_vld[slot] = 1'b0;
        spur = 1'b0;
        rst = rst_req;
        rq0_rd_en   = (rq0_q.size() > 0) && gate0;
        rq1_rd_en   = (rq1_q.size() > 0) && gate1;
        rq0_rd_addr = (rq0_q.size() > 0) ? rq0_q[0] : AW'($urandom);
        rq1_rd_addr = (rq1_q.size() > 0) ? rq1_q[0] : AW'($urandom);
        @(negedge clk);
        chk(rq0_rd_rdy === (!rst && m_owner == 0 && m_out < TD), "rq0_rd_rdy", rq0_rd_rdy, (!rst && m_owner == 0 && m_out < TD));
        chk(rq1_rd_rdy === (!rst && m_owner == 1 && m_out < TD), "rq1_rd_rdy", rq1_rd_rdy, (!rst && m_owner == 1 && m_out < TD));
        @(posedge clk);
        e0 = rq0_rd_en;
        e1 = rq1_rd_en;
        if (rst) begin
            m_owner = -1; m_last = 1; m_beats = 0; m_out = 0;
            exp0.delete(); exp1.delete();
        end else begin
            acc = ((m_owner == 0 && e0) || (m_owner == 1 && e1)) && m_out < TD;
            pop = bm_dout_vld && m_out > 0;
            if (acc) begin
                if (m_owner == 0) begin
                    a = rq0_rd_addr; exp0.push_back(mem[a]); void'(rq0_q.pop_front());
                end else begin
                    a = rq1_rd_addr; exp1.push_back(mem[a]); void'(rq1_q.pop_front());
                end
                bmq.push_back('{addr: a, cyc: cyc + 1});
                m_beats++;
            end
            m_out = m_out + int'(acc) - int'(pop);
            if (m_owner < 0) begin
                m_owner = pick(e0, e1, m_last);
            end else if (!(m_owner == 0 ? e0 : e1) || (acc && m_beats == BL)) begin
                m_last  = m_owner;
                m_beats = 0;
                m_owner = pick(e0, e1, m_last);
            end
        end
        cyc++;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && busy(); i++) cycle();
        chk(!busy(), name, m_out, 0);
    endtask

    task automatic check_quiet(input string name);
        #1;
        chk(bm_rd_en === 1'b0, {name, "_bm_rd_en"}, bm_rd_en, 0);
        chk(bm_rd_addr === '0, {name, "_bm_rd_addr"}, bm_rd_addr, 0);
        chk(rq0_dout_vld === 1'b0 && rq1_dout_vld === 1'b0, {name, "_dout_vld"}, {rq1_dout_vld, rq0_dout_vld}, 0);
        chk(rq0_dout === '0 && rq1_dout === '0, {name, "_dout"}, rq0_dout, 0);
        chk(rq0_rd_rdy === 1'b0 && rq1_rd_rdy === 1'b0, {name, "_rd_rdy"}, {rq1_rd_rdy, rq0_rd_rdy}, 0);
    endtask

    task automatic pulse_reset(input int n);
        rst_req = 1'b1;
        repeat (n) cycle();
        rst_req = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a BM read or a routed response.
    always @(negedge clk) begin
        bm_exp_t e;
        if (bm_rd_en === 1'b1) begin
            chk(bmq.size() > 0, "bm_unexpected", bm_rd_addr, 0);
            if (bmq.size() > 0) begin
                e = bmq.pop_front();
                chk(bm_rd_addr === e.addr, "bm_rd_addr", bm_rd_addr, e.addr);
                chk(cyc == e.cyc, "bm_rd_timing", cyc, e.cyc);
            end
        end
        if (bmq.size() > 0) begin
            chk(bmq[0].cyc >= cyc, "bm_rd_missing", cyc, bmq[0].cyc);
            if (bmq[0].cyc < cyc) void'(bmq.pop_front());
        end
        if (rq0_dout_vld === 1'b1 || rq1_dout_vld === 1'b1)
            chk(!(rq0_dout_vld === 1'b1 && rq1_dout_vld === 1'b1), "dout_vld_both", 3, 1);
        if (rq0_dout_vld === 1'b1) begin
            chk(exp0.size() > 0, "rq0_unexpected", rq0_dout, 0);
            if (exp0.size() > 0) begin
                e.addr = '0;
                chk(rq0_dout === exp0[0], "rq0_dout", rq0_dout, exp0[0]);
                void'(exp0.pop_front());
            end
        end
        if (rq1_dout_vld === 1'b1) begin
            chk(exp1.size() > 0, "rq1_unexpected", rq1_dout, 0);
            if (exp1.size() > 0) begin
                chk(rq1_dout === exp1[0], "rq1_dout", rq1_dout, exp1[0]);
                void'(exp1.pop_front());
            end
        end
    end

    initial begin
        int lats[4];
        lats[0] = 1; lats[1] = 2; lats[2] = 3; lats[3] = 5;
        for (int i = 0; i < `BM_DEPTH; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 64; i++) ring_vld[i] = 1'b0;
        rst = 1'b1; rq0_rd_en = 1'b0; rq1_rd_en = 1'b0;
        rq0_rd_addr = '0; rq1_rd_addr = '0; bm_dout = '0; bm_dout_vld = 1'b0;
        @(posedge clk);
        repeat (2) cycle();
        check_quiet("reset");
        rst_req = 1'b0;

        // rq0 alone, sequential addresses
        for (int a = 16; a < 20; a++) rq0_q.push_back(AW'(a));
        drain("s1_drain");

        // both requesting from reset: rq0, rq1, rq0 bursts with direct handover
        pulse_reset(1);
        for (int i = 0; i < 12; i++) begin
            rq0_q.push_back(AW'(32 + i));
            rq1_q.push_back(AW'(64 + i));
        end
        drain("s2_drain");

        // rq1 abandons after 2 beats while rq0 waits
        rq1_q.push_back(AW'(96)); rq1_q.push_back(AW'(97));
        cycle();
        for (int i = 0; i < 4; i++) rq0_q.push_back(AW'(100 + i));
        drain("s3_drain");

        // long latency fills the tag FIFO mid-burst
        lat = 12;
        rq1_q.push_back(AW'(120)); rq1_q.push_back(AW'(121));
        for (int i = 0; i < 40 && rq1_q.size() > 0; i++) cycle();
        cycle();
        for (int i = 0; i < 6; i++) begin
            rq0_q.push_back(AW'(130 + i));
            rq1_q.push_back(AW'(140 + i));
        end
        drain("s4_drain");
        lat = 2;

        // reset with two reads in flight; their returns must be dropped
        rq0_q.push_back(AW'(150)); rq0_q.push_back(AW'(151));
        repeat (3) cycle();
        pulse_reset(1);
        check_quiet("post_rst");
        drain("s5_flush");
        for (int i = 0; i < 4; i++) rq0_q.push_back(AW'(160 + i));
        drain("s5_drain");

        // spurious return with nothing outstanding
        spur = 1'b1;
        repeat (3) cycle();
        drain("s6_drain");

        // randomized traffic at several latencies
        for (int seg = 0; seg < 4; seg++) begin
            lat = lats[seg];
            for (int c = 0; c < 300; c++) begin
                if (rq0_q.size() < 6 && $urandom_range(0, 99) < 30) rq0_q.push_back(AW'($urandom));
                if (rq1_q.size() < 6 && $urandom_range(0, 99) < 30) rq1_q.push_back(AW'($urandom));
                gate0 = ($urandom_range(0, 9) != 0);
                gate1 = ($urandom_range(0, 9) != 0);
                if (m_out == 0 && ring_cnt == 0 && $urandom_range(0, 19) == 0) spur = 1'b1;
                cycle();
            end
            gate0 = 1'b1; gate1 = 1'b1;
            drain("rand_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bm_rd_arb.md
BM_RD_ARB -- requirements
Module: Bm_rd_arb

Interface
REQ-001 Parameter BURST_LEN, default 4, SHALL set the maximum consecutive beats one requester holds the BM read port.
REQ-002 Parameter TAG_DEPTH, default 8, SHALL set the maximum outstanding reads, power of 2, at least the BM read latency plus 2.
REQ-003 Port clk, in, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port rst, in, 1: reset, synchronous and active-high.
REQ-005 Ports rq0_rd_en / rq1_rd_en, in, 1: a requester presents a read beat.
REQ-006 Ports rq0_rd_addr / rq1_rd_addr, in, $clog2(`BM_DEPTH): beat address.
REQ-007 Ports rq0_rd_rdy / rq1_rd_rdy, out, 1: the beat is accepted this cycle when rd_en && rd_rdy.
REQ-008 Ports bm_rd_en, out, 1 and bm_rd_addr, out, $clog2(`BM_DEPTH): the shared BM read port.
REQ-009 Ports bm_dout, in, `BM_DATA_WIDTH and bm_dout_vld, in, 1: BM read data return, in issue order, any fixed latency.
REQ-010 Ports rq0_dout / rq1_dout, out, `BM_DATA_WIDTH, and rq0_dout_vld / rq1_dout_vld, out, 1: routed return data.

Function
REQ-011 Arbiter FSM states SHALL be IDLE, OWN0 and OWN1, plus a register last_owner.
- IDLE, exactly one rd_en high: go to that requester's OWN state.
- IDLE, both high: go to OWN of the requester that is not last_owner.
- IDLE, neither high: stay in IDLE.
REQ-012 rqX_rd_rdy SHALL be combinational: high only when state is OWNX and the tag FIFO is not full. rd_rdy SHALL always be low in IDLE, so a grant always costs one bubble cycle.
REQ-013 In OWNX, each accepted beat SHALL increment beat_cnt, width $clog2(BURST_LEN+1).
REQ-014 OWNX SHALL end when either of these holds:
- a beat is accepted with beat_cnt == BURST_LEN-1;
- rqX_rd_en is low in an OWNX cycle (the burst is abandoned).
On exit: last_owner <= X, beat_cnt <= 0, and the next state follows the IDLE rule of REQ-011 using the current rd_en values. If the other requester is requesting, ownership SHALL pass directly to it.
REQ-015 A stall caused by a full FIFO (rd_en high, rd_rdy low) SHALL NOT end the burst and SHALL NOT count as a beat.
REQ-016 An accepted beat SHALL appear on bm_rd_en/bm_rd_addr exactly 1 cycle later (registered). Otherwise bm_rd_en SHALL be 0 and bm_rd_addr SHALL hold its value.
REQ-017 Each accepted beat SHALL push the owner id (1 bit) into the tag FIFO in the same cycle the beat is registered.
REQ-018 Each bm_dout_vld SHALL pop one tag. rq<tag>_dout_vld SHALL be driven exactly 1 cycle later (registered), with rq0_dout = rq1_dout = the registered bm_dout.
REQ-019 bm_dout_vld while the tag FIFO is empty SHALL be dropped: no dout_vld is raised and the FIFO stays empty.
REQ-020 When a push and a pop occur in the same cycle, the occupancy SHALL stay unchanged; this is legal at full and at empty.
REQ-021 Responses SHALL reach each requester in that requester's issue order, with no loss or duplication.

Reset
REQ-022 While rst is high, the block SHALL take these values:
- state = IDLE, last_owner = 1 (rq0 wins the first tie), beat_cnt = 0;
- tag FIFO empty;
- bm_rd_en = 0, bm_rd_addr = 0;
- rqX_dout_vld = 0, rqX_dout = 0, rqX_rd_rdy = 0.
REQ-023 Reset asserted mid-burst SHALL abort the burst. Data for reads still in flight SHALL then be dropped per REQ-019.

Structure
REQ-024 BM_DEPTH and BM_DATA_WIDTH SHALL come from the shared include incl.vh; no new package constants are added.
REQ-025 The tag FIFO SHALL be a separate sub-module Bm_tag_fifo (synchronous FIFO, 1-bit data, depth TAG_DEPTH, full/empty flags, synchronous active-high rst).

Verification
REQ-026 The bench SHALL cover these directed scenarios (BM model latency 2, BURST_LEN 4):
- rq0 only, addr 0x10..0x13 back-to-back: bm_rd_addr 0x10..0x13 on consecutive cycles, first beat 2 cycles after rd_en rises; rq0_dout_vld x4 with data matching the model; rq1_dout_vld never high.
- Both requesting continuously from reset: grants rq0 x4, rq1 x4, rq0 x4; one IDLE bubble after reset only, with direct handover between bursts.
- rq1 drops rd_en after 2 beats while rq0 waits: rq1 burst ends, rq0 granted the next cycle, rq1 receives exactly 2 responses.
- BM model latency raised to 12 with TAG_DEPTH 8: rd_rdy drops after 8 outstanding reads and resumes on the first pop; no response lost; burst not terminated by the stall.
- rst pulsed for 1 cycle with 2 reads in flight: both returning bm_dout_vld pulses dropped; state IDLE, all dout_vld low; the next rq0 request is served normally.
- Spurious bm_dout_vld with the FIFO empty: no rqX_dout_vld raised.
